// File: rtl/ram_stream_ctrl.sv
// rtl/ram_stream_ctrl.sv - record/playback sequencer between a sample stream and the DDR2 RAM wrapper
// Optional macro LOOP_PLAYBACK_EN: playback restarts at address 0 at end of data until stop.
module ram_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 26
) (
  input  logic              systemCLK,
  input  logic              reset,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_rd_req,
  output logic              ram_rd_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_rd_pres,
  input  logic              ram_rdy,
  input  logic [ADDR_W-1:0] ram_max_addr,
  output logic [ADDR_W:0]   rec_len,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE,
    REC_WAIT,
    REC_WRITE,
    PLAY_REQ,
    PLAY_WAIT,
    PLAY_OUT
  } state_t;

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] odata_n;
  logic              ovalid_n;
  logic              ovf_n;
  logic [ADDR_W:0]   len_n;
  logic              stop_pend, stop_pend_n;
  logic              stop_any;
  logic              at_end;
  logic              we_c, rd_req_c, rd_ack_c, in_ready_c;

  // A stop seen mid-write or mid-read is remembered so the RAM transaction always finishes.
  assign stop_any = stop | stop_pend;
  assign at_end   = (({1'b0, ram_addr}) + LEN_ONE) == rec_len;

  always_ff @(posedge systemCLK) begin
    if (reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      rec_len   <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      out_data  <= odata_n;
      out_valid <= ovalid_n;
      overflow  <= ovf_n;
      rec_len   <= len_n;
      stop_pend <= stop_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = ram_addr;
    wdata_n     = ram_wdata;
    odata_n     = out_data;
    ovalid_n    = out_valid;
    ovf_n       = overflow;
    len_n       = rec_len;
    stop_pend_n = stop_pend;
    we_c        = 1'b0;
    rd_req_c    = 1'b0;
    rd_ack_c    = 1'b0;
    in_ready_c  = 1'b0;
    case (state)
      IDLE: begin
        stop_pend_n = 1'b0;
        if (start_rec) begin
          addr_n  = '0;
          ovf_n   = 1'b0;
          state_n = REC_WAIT;
        end else if (start_play && (rec_len != '0)) begin
          addr_n  = '0;
          state_n = PLAY_REQ;
        end
      end
      REC_WAIT: begin
        if (stop_any) begin
          len_n       = {1'b0, ram_addr};
          stop_pend_n = 1'b0;
          state_n     = IDLE;
        end else begin
          in_ready_c = ram_rdy;
          if (in_valid && ram_rdy) begin
            wdata_n = in_data;
            state_n = REC_WRITE;
          end
        end
      end
      REC_WRITE: begin
        if (stop) stop_pend_n = 1'b1;
        if (ram_rdy) begin
          we_c = 1'b1;
          if (ram_addr == ram_max_addr) begin
            len_n       = {1'b0, ram_addr} + LEN_ONE;
            ovf_n       = 1'b1;
            stop_pend_n = 1'b0;
            state_n     = IDLE;
          end else begin
            addr_n  = ram_addr + ADDR_ONE;
            state_n = REC_WAIT;
          end
        end
      end
      PLAY_REQ: begin
        if (stop_any) begin
          stop_pend_n = 1'b0;
          state_n     = IDLE;
        end else if (ram_rdy) begin
          rd_req_c = 1'b1;
          state_n  = PLAY_WAIT;
        end
      end
      PLAY_WAIT: begin
        if (stop) stop_pend_n = 1'b1;
        if (ram_rd_pres) begin
          rd_ack_c = 1'b1;
          odata_n  = ram_rdata;
          ovalid_n = 1'b1;
          state_n  = PLAY_OUT;
        end
      end
      PLAY_OUT: begin
        if (stop) stop_pend_n = 1'b1;
        if (out_ready) begin
          ovalid_n = 1'b0;
          if (stop_any) begin
            stop_pend_n = 1'b0;
            state_n     = IDLE;
          end else if (at_end) begin
`ifdef LOOP_PLAYBACK_EN
            addr_n  = '0;
            state_n = PLAY_REQ;
`else
            state_n = IDLE;
`endif
          end else begin
            addr_n  = ram_addr + ADDR_ONE;
            state_n = PLAY_REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Combinational strobes are masked by reset so no command escapes in the reset cycle.
  assign ram_we     = we_c & ~reset;
  assign ram_rd_req = rd_req_c & ~reset;
  assign ram_rd_ack = rd_ack_c & ~reset;
  assign in_ready   = in_ready_c & ~reset;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// tb/tb_ram_stream_ctrl.sv - self-checking bench for ram_stream_ctrl with a latency-modelled RAM
module tb_ram_stream_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 26;
  localparam int LAT = 4;

  logic          systemCLK = 1'b0;
  logic          reset, start_rec, start_play, stop;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we, ram_rd_req, ram_rd_ack, ram_rd_pres, ram_rdy;
  logic [AW-1:0] ram_max_addr;
  logic [AW:0]   rec_len;
  logic          busy, overflow;

  always #5 systemCLK = ~systemCLK;

  ram_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .systemCLK(systemCLK), .reset(reset), .start_rec(start_rec), .start_play(start_play),
    .stop(stop), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rd_req(ram_rd_req),
    .ram_rd_ack(ram_rd_ack), .ram_rdata(ram_rdata), .ram_rd_pres(ram_rd_pres),
    .ram_rdy(ram_rdy), .ram_max_addr(ram_max_addr), .rec_len(rec_len), .busy(busy),
    .overflow(overflow)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] src_q[$], acc_q[$], rec_q[$], got_q[$];
  logic [DW-1:0] mem[int];
  int            n_we, n_req, n_ack;
  bit            rd_pend;
  int            rd_cnt, rd_addr;
  bit            hold_v;
  logic [DW-1:0] hold_d;

  // One clock: observe outputs just after the falling edge, update the RAM/sink model, advance.
  task automatic cycle();
    #1;
    if (in_valid && in_ready) acc_q.push_back(in_data);
    if (ram_we) begin
      checks++;
      if (n_we >= acc_q.size() || ram_addr !== AW'(n_we) || ram_wdata !== acc_q[n_we]) begin
        errors++;
        $display("FAIL write %0d: got addr %0d data %02h, expected addr %0d data %02h", n_we,
                 ram_addr, ram_wdata, n_we, (n_we < acc_q.size()) ? acc_q[n_we] : 8'hxx);
      end
      mem[int'(ram_addr)] = ram_wdata;
      n_we++;
    end
    if (ram_rd_req) begin
      n_req++;
      checks++;
      if (out_valid) begin
        errors++;
        $display("FAIL rd_req_while_out_valid: rd_req 1 with out_valid 1, expected rd_req 0");
      end
      rd_pend = 1'b1;
      rd_cnt  = LAT;
      rd_addr = int'(ram_addr);
    end
    if (ram_rd_ack) begin
      n_ack++;
      checks++;
      if (!ram_rd_pres) begin
        errors++;
        $display("FAIL rd_ack_without_data: rd_ack 1 with rd_pres 0, expected rd_ack 0");
      end
      rd_pend = 1'b0;
    end
    if (hold_v) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_d) begin
        errors++;
        $display("FAIL out_hold: got valid %0b data %02h, expected valid 1 data %02h",
                 out_valid, out_data, hold_d);
      end
    end
    if (out_valid && out_ready) got_q.push_back(out_data);
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    @(negedge systemCLK);
    if (rd_pend) begin
      if (rd_cnt > 0) rd_cnt--;
      ram_rd_pres = (rd_cnt == 0);
      ram_rdata   = (ram_rd_pres && mem.exists(rd_addr)) ? mem[rd_addr] : '0;
    end else begin
      ram_rd_pres = 1'b0;
      ram_rdata   = '0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy %0b after %0d cycles, expected 0", busy, budget);
    end
  endtask

  task automatic do_record(input int valid_pct, input int rdy_pct, input bit stall);
    int budget = 2000;
    int prev;
    int stall_left = 0;
    acc_q.delete();
    n_we = 0;
    ram_rdy = 1'b1;
    start_rec = 1'b1;
    cycle();
    start_rec = 1'b0;
    while (busy && acc_q.size() < src_q.size() && budget > 0) begin
      in_data  = src_q[acc_q.size()];
      in_valid = ($urandom_range(99) < valid_pct);
      if (stall_left > 0) begin
        ram_rdy = 1'b0;
        stall_left--;
      end else begin
        ram_rdy = ($urandom_range(99) < rdy_pct);
      end
      prev = acc_q.size();
      cycle();
      budget--;
      if (stall && acc_q.size() != prev) stall_left = 3;
    end
    in_valid = 1'b0;
    for (int i = 0; i < stall_left; i++) begin
      ram_rdy = 1'b0;
      cycle();
    end
    ram_rdy = 1'b1;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL record_timeout: accepted %0d, expected %0d", acc_q.size(), src_q.size());
    end
    if (busy) begin
      stop = 1'b1;
      cycle();
      stop = 1'b0;
    end
    wait_idle(50);
    rec_q = acc_q;
  endtask

  task automatic do_play(input int target, input int ready_pct, input bit hold);
    int budget = 3000;
    int prev;
    int req_before;
    bit held = 1'b0;
    got_q.delete();
    n_req = 0;
    n_ack = 0;
    out_ready = 1'b1;
    start_play = 1'b1;
    cycle();
    start_play = 1'b0;
    while (busy && budget > 0) begin
      if (hold && !held && out_valid) begin
        held = 1'b1;
        req_before = n_req;
        out_ready = 1'b0;
        repeat (5) cycle();
        checks++;
        if (n_req != req_before || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL play_stall: got rd_req %0d valid %0b, expected rd_req %0d valid 1",
                   n_req - req_before, out_valid, 0);
        end
      end
      out_ready = ($urandom_range(99) < ready_pct);
      stop = (got_q.size() >= target);
      prev = got_q.size();
      cycle();
      budget--;
`ifndef LOOP_PLAYBACK_EN
      if (got_q.size() == target && prev < target) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL play_end_busy: got busy %0b after last sample, expected 0", busy);
        end
      end
`endif
    end
    stop = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got_q.size() != target || n_req != target || n_ack != target) begin
      errors++;
      $display("FAIL play_counts: got samples %0d req %0d ack %0d, expected %0d each",
               got_q.size(), n_req, n_ack, target);
    end
    for (int i = 0; i < target && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== rec_q[i % rec_q.size()]) begin
        errors++;
        $display("FAIL play_data[%0d]: got %02h, expected %02h", i, got_q[i],
                 rec_q[i % rec_q.size()]);
      end
    end
  endtask

  task automatic check_rec(input int exp_len, input bit exp_ovf);
    checks++;
    if (rec_len !== (AW+1)'(exp_len) || n_we != exp_len || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL rec_result: got rec_len %0d writes %0d overflow %0b, expected %0d %0d %0b",
               rec_len, n_we, overflow, exp_len, exp_len, exp_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cycle();
    #1;
    checks++;
    if ({in_ready, out_valid, ram_we, ram_rd_req, ram_rd_ack, busy, overflow} !== 7'b0 ||
        rec_len !== '0 || ram_addr !== '0 || out_data !== '0 || ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got flags %07b rec_len %0d addr %0d, expected all 0",
               {in_ready, out_valid, ram_we, ram_rd_req, ram_rd_ack, busy, overflow},
               rec_len, ram_addr);
    end
    reset = 1'b0;
    cycle();
    start_play = 1'b1;
    cycle();
    start_play = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || n_req != 0) begin
      errors++;
      $display("FAIL play_empty: got busy %0b req %0d, expected 0 0", busy, n_req);
    end
  endtask

  task automatic test_record();
    src_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    do_record(70, 100, 1'b0);
    check_rec(5, 1'b0);
  endtask

  task automatic test_playback();
    do_play(5, 100, 1'b0);
  endtask

  task automatic test_overflow();
    ram_max_addr = AW'(3);
    src_q = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    do_record(100, 100, 1'b0);
    check_rec(4, 1'b1);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_in_ready: got %0b, expected 0", in_ready);
    end
    in_valid = 1'b0;
    ram_max_addr = AW'(1000);
    @(negedge systemCLK);
  endtask

  task automatic test_stall();
    src_q = {8'h61, 8'h62, 8'h63, 8'h64};
    do_record(100, 100, 1'b1);
    check_rec(4, 1'b0);
    do_play(4, 100, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int n = $urandom_range(12, 1);
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom_range(255)));
      do_record(60, 70, 1'b0);
      check_rec(n, 1'b0);
      do_play(n, 60, 1'b0);
    end
  endtask

  task automatic test_stop_mid_read();
    int budget = 100;
    src_q = {8'h31, 8'h32, 8'h33};
    do_record(100, 100, 1'b0);
    got_q.delete();
    n_req = 0;
    n_ack = 0;
    out_ready = 1'b1;
    start_play = 1'b1;
    cycle();
    start_play = 1'b0;
    while (n_req == 0 && budget > 0) begin
      cycle();
      budget--;
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    wait_idle(50);
    checks++;
    if (n_req != 1 || n_ack != 1 || got_q.size() != 1) begin
      errors++;
      $display("FAIL stop_read_counts: got req %0d ack %0d samples %0d, expected 1 1 1",
               n_req, n_ack, got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'h31) begin
        errors++;
        $display("FAIL stop_read_data: got %02h, expected 31", got_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    acc_q.delete();
    n_we = 0;
    ram_rdy = 1'b1;
    start_rec = 1'b1;
    cycle();
    start_rec = 1'b0;
    in_data = 8'h41;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    ram_rdy = 1'b0;
    cycle();
    checks++;
    if (acc_q.size() != 1 || busy !== 1'b1 || n_we != 0) begin
      errors++;
      $display("FAIL pre_reset: got accepted %0d busy %0b writes %0d, expected 1 1 0",
               acc_q.size(), busy, n_we);
    end
    reset = 1'b1;
    ram_rdy = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, ram_we, ram_rd_req, ram_rd_ack, busy, overflow} !== 7'b0 ||
        rec_len !== '0 || ram_addr !== '0 || out_data !== '0 || ram_wdata !== '0 || n_we != 0) begin
      errors++;
      $display("FAIL reset_mid_write: got flags %07b rec_len %0d wdata %02h writes %0d, expected all 0",
               {in_ready, out_valid, ram_we, ram_rd_req, ram_rd_ack, busy, overflow},
               rec_len, ram_wdata, n_we);
    end
    @(negedge systemCLK);
  endtask

`ifdef LOOP_PLAYBACK_EN
  task automatic test_loop();
    src_q = {8'hA5, 8'h5A};
    do_record(100, 100, 1'b0);
    check_rec(2, 1'b0);
    do_play(6, 80, 1'b0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    start_rec = 1'b0;
    start_play = 1'b0;
    stop = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ram_rdata = '0;
    ram_rd_pres = 1'b0;
    ram_rdy = 1'b1;
    ram_max_addr = AW'(1000);
    n_we = 0;
    n_req = 0;
    n_ack = 0;
    rd_pend = 1'b0;
    rd_cnt = 0;
    rd_addr = 0;
    hold_v = 1'b0;
    hold_d = '0;
    @(negedge systemCLK);
    test_reset();
    test_record();
    test_playback();
    test_overflow();
    test_stall();
    test_random();
    test_stop_mid_read();
    test_reset_mid_write();
`ifdef LOOP_PLAYBACK_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_ctrl.md
Name: ram_stream_ctrl

Overview:
Parametrised record/playback sequencer between a streaming sample source/sink and the DDR2 RAM wrapper. It replaces the single write-then-readback test FSM. It adds:
- Continuous sequential recording of DATA_W-bit samples into consecutive RAM addresses.
- Length tracking, and playback of the recorded region to a valid/ready sink.
- Overflow and stop handling.

It sits between the audio front-end and the RAM wrapper's address/data/write-enable/read-request/read-ack ports.

Parameters:
DATA_W, 8, sample and RAM data width in bits
ADDR_W, 26, RAM address width in bits

Ports:
systemCLK  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
start_rec  in  1  pulse: begin recording at address 0
start_play  in  1  pulse: begin playback at address 0
stop  in  1  pulse: end current operation
in_data  in  DATA_W  sample to record
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data this cycle
out_data  out  DATA_W  played-back sample
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts out_data
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rd_req  out  1  RAM read request
ram_rd_ack  out  1  read acknowledge to wrapper
ram_rdata  in  DATA_W  RAM read data
ram_rd_pres  in  1  read data present
ram_rdy  in  1  RAM ready; no new command when low
ram_max_addr  in  ADDR_W  highest usable address
rec_len  out  ADDR_W+1  number of samples recorded
busy  out  1  state != IDLE
overflow  out  1  sticky: last recording hit ram_max_addr

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; rec_len 0; overflow 0.
- States: IDLE, REC_WAIT, REC_WRITE, PLAY_REQ, PLAY_WAIT, PLAY_OUT.
- IDLE:
  - start_rec: ram_addr<=0, overflow<=0 -> REC_WAIT.
  - Else start_play with rec_len!=0: ram_addr<=0 -> PLAY_REQ.
  - start_play with rec_len==0: ignored.
  - start_rec and start_play in the same cycle: record wins.
- REC_WAIT:
  - in_ready = ram_rdy (combinational).
  - stop: rec_len<=ram_addr -> IDLE; the sample is not accepted in that cycle (in_ready forced 0).
  - in_valid & in_ready: ram_wdata<=in_data -> REC_WRITE.
- REC_WRITE:
  - ram_we=1 for exactly one cycle, issued only while ram_rdy=1; otherwise the state holds with ram_we=0.
  - After the write:
    - If ram_addr==ram_max_addr: rec_len<=ram_addr+1, overflow<=1 -> IDLE.
    - Else ram_addr<=ram_addr+1 -> REC_WAIT.
  - stop in REC_WRITE is deferred: it is latched and honoured in REC_WAIT, so the in-flight write always completes.
- PLAY_REQ:
  - stop -> IDLE.
  - Else, when ram_rdy: ram_rd_req=1 for one cycle -> PLAY_WAIT.
- PLAY_WAIT:
  - Wait for ram_rd_pres.
  - When it arrives: out_data<=ram_rdata, ram_rd_ack=1 for one cycle, out_valid<=1 -> PLAY_OUT.
  - stop is latched and applied after the read completes; a read is never abandoned.
- PLAY_OUT:
  - out_valid and out_data are held stable until out_ready. The handshake cycle clears out_valid.
  - Then, if a stop is latched -> IDLE.
  - Else if ram_addr+1==rec_len -> end of data (see Optional Feature).
  - Else ram_addr<=ram_addr+1 -> PLAY_REQ.
- Throughput: at best one sample per 2 cycles while recording and one per 3 cycles plus RAM read latency while playing.
- rec_len is updated only when a recording ends, and is unchanged by playback.
- The address counter never exceeds ram_max_addr; no wrap-around while recording.
- reset asserted in any state: immediate return to reset values; any pending RAM command is dropped.

Optional Feature:
Macro LOOP_PLAYBACK_EN.
- Defined: at end of data in PLAY_OUT, ram_addr<=0 -> PLAY_REQ. Playback repeats until stop.
- Undefined: at end of data -> IDLE; busy falls the next cycle.

Test Plan:
1. Record stream: start_rec, feed 5 samples 0x11..0x15 with ram_rdy=1, then stop -> 5 ram_we pulses at addresses 0..4 with data 0x11..0x15; rec_len=5; overflow=0.
2. Playback: after test 1, start_play with out_ready=1 and RAM model latency 4 -> out_data 0x11..0x15 in order; one rd_req and one rd_ack per sample; IDLE after the 5th sample (LOOP off).
3. Overflow: ram_max_addr=3, record 6 valid samples -> 4 writes at addresses 0..3; rec_len=4; overflow=1; in_ready=0 afterwards.
4. Stall handling:
   - Drop ram_rdy for 3 cycles during REC_WRITE -> ram_we delayed, not duplicated.
   - Hold out_ready=0 for 5 cycles in playback -> out_data stable, no new rd_req.
5. Stop and reset mid-read:
   - stop in PLAY_WAIT -> read completes, one rd_ack, sample presented, then IDLE.
   - Separately, reset in REC_WRITE -> all outputs 0 and rec_len=0 on the next cycle.
6. LOOP_PLAYBACK_EN defined, rec_len=2 -> out_data sequence A,B,A,B,... until stop.
